// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared definitions for the SRAM request-port arbiter.
//   arb_state_e : arbiter state machine encoding (ARB_IDLE, ARB_WAIT)
//   DW, AW      : data and address widths of every requester and of ext_sram
package sram_arb_pkg;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational request picker.
//   pend    in  NPORTS : pending request flags
//   ptr     in  PW     : last granted port (used only in round-robin mode)
//   rr_mode in  1      : 1 = round-robin starting after ptr, 0 = lowest index wins
//   gnt_oh  out NPORTS : one-hot selected port (all zero when nothing pending)
//   gnt_idx out PW     : index of the selected port
//   any     out 1      : at least one request pending
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int PW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] pend,
  input  logic [PW-1:0]     ptr,
  input  logic              rr_mode,
  output logic [NPORTS-1:0] gnt_oh,
  output logic [PW-1:0]     gnt_idx,
  output logic              any
);

  logic [PW-1:0] cand;
  logic          found;

  // Scan candidates in priority order; the first pending one wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    any     = |pend;
    for (int k = 0; k < NPORTS; k++) begin
      // Round-robin order starts at the port just after the last grant.
      if (rr_mode) begin
        cand = PW'((int'(ptr) + 1 + k) % NPORTS);
      end else begin
        cand = PW'(k);
      end
      if (!found && pend[cand]) begin
        found         = 1'b1;
        gnt_oh[cand]  = 1'b1;
        gnt_idx       = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single ext_sram request port between NPORTS
// requesters. Strobes are captured into per-port pending registers, one
// pending port is granted at a time and replayed to the SRAM controller as a
// single-cycle m_stb, and the controller's ack/read data are routed back.
//
// Build option: SRAM_ARB_RR_EN defined selects round-robin arbitration;
// undefined selects fixed priority (lowest index wins, pointer compiled out).
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   s_stb/s_rw          : per-port request strobe and direction (1 = write)
//   s_addr/s_dtw        : per-port address / write data, port i at [32i+31:32i]
//   s_ack               : per-port completion pulse
//   s_dtr               : read data broadcast to all ports, valid with s_ack
//   m_stb/m_rw/m_addr/m_dtw : request to the SRAM controller
//   m_ack/m_dtr         : completion and read data from the SRAM controller
//   busy                : transaction in flight
//   grant               : index of the current or last granted port
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int PW     = $clog2(NPORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    s_stb,
  input  logic [NPORTS-1:0]    s_rw,
  input  logic [AW*NPORTS-1:0] s_addr,
  input  logic [DW*NPORTS-1:0] s_dtw,
  output logic [NPORTS-1:0]    s_ack,
  output logic [DW-1:0]        s_dtr,
  output logic                 m_stb,
  output logic                 m_rw,
  output logic [AW-1:0]        m_addr,
  output logic [DW-1:0]        m_dtw,
  input  logic                 m_ack,
  input  logic [DW-1:0]        m_dtr,
  output logic                 busy,
  output logic [PW-1:0]        grant
);

  arb_state_e state;
  arb_state_e next_state;

  logic [NPORTS-1:0] pend;
  logic [NPORTS-1:0] req_rw;
  logic [AW-1:0]     req_addr [NPORTS];
  logic [DW-1:0]     req_dtw  [NPORTS];

  logic [NPORTS-1:0] grant_oh;
  logic [NPORTS-1:0] pick_oh;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [PW-1:0]     rr_ptr;
  logic              rr_mode;

  logic do_grant;
  logic do_done;

  sram_arb_pick #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_pick (
    .pend    (pend),
    .ptr     (rr_ptr),
    .rr_mode (rr_mode),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

`ifdef SRAM_ARB_RR_EN
  assign rr_mode = 1'b1;

  // Round-robin pointer: remembers the last granted port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= PW'(NPORTS - 1);
    end else if (do_grant) begin
      rr_ptr <= pick_idx;
    end
  end
`else
  assign rr_mode = 1'b0;
  assign rr_ptr  = '0;
`endif

  // State register; busy is registered from the next state so it tracks WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ARB_WAIT);
    end
  end

  // Next-state logic: grant from IDLE, complete on m_ack in WAIT.
  always_comb begin
    next_state = state;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    case (state)
      ARB_IDLE: begin
        // m_ack is ignored here: nothing is outstanding.
        if (pick_any) begin
          next_state = ARB_WAIT;
          do_grant   = 1'b1;
        end else begin
          next_state = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if (m_ack) begin
          next_state = ARB_IDLE;
          do_done    = 1'b1;
        end else begin
          next_state = ARB_WAIT;
        end
      end
      default: begin
        next_state = ARB_IDLE;
      end
    endcase
  end

  // Pending capture. A strobe on an already-pending port is dropped; the
  // granted port is released on completion, so a strobe in its s_ack cycle
  // sees pend clear and is accepted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (reset) begin
        pend[i]     <= 1'b0;
        req_rw[i]   <= 1'b0;
        req_addr[i] <= '0;
        req_dtw[i]  <= '0;
      end else if (s_stb[i] && !pend[i]) begin
        pend[i]     <= 1'b1;
        req_rw[i]   <= s_rw[i];
        req_addr[i] <= s_addr[AW*i +: AW];
        req_dtw[i]  <= s_dtw[DW*i +: DW];
      end else if (do_done && (grant == PW'(i))) begin
        pend[i] <= 1'b0;
      end
    end
  end

  // Controller-side request: one-cycle strobe, fields held through WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_stb    <= 1'b0;
      m_rw     <= 1'b0;
      m_addr   <= '0;
      m_dtw    <= '0;
      grant    <= '0;
      grant_oh <= '0;
    end else begin
      m_stb <= do_grant;
      if (do_grant) begin
        m_rw     <= req_rw[pick_idx];
        m_addr   <= req_addr[pick_idx];
        m_dtw    <= req_dtw[pick_idx];
        grant    <= pick_idx;
        grant_oh <= pick_oh;
      end
    end
  end

  // Return path: s_ack pulses on the granted port; read data captured for
  // writes too so s_dtr always reflects the last completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ack <= '0;
      s_dtr <= '0;
    end else begin
      if (do_done) begin
        s_ack <= grant_oh;
        s_dtr <= m_dtr;
      end else begin
        s_ack <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int NPORTS = 3;
  localparam int PW     = $clog2(NPORTS);
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NPORTS-1:0]    s_stb;
  logic [NPORTS-1:0]    s_rw;
  logic [32*NPORTS-1:0] s_addr;
  logic [32*NPORTS-1:0] s_dtw;
  logic [NPORTS-1:0]    s_ack;
  logic [31:0]          s_dtr;
  logic                 m_stb;
  logic                 m_rw;
  logic [31:0]          m_addr;
  logic [31:0]          m_dtw;
  logic                 m_ack;
  logic [31:0]          m_dtr;
  logic                 busy;
  logic [PW-1:0]        grant;

  sram_arbiter #(.NPORTS(NPORTS), .PW(PW)) dut (
    .clk(clk), .reset(reset), .s_stb(s_stb), .s_rw(s_rw), .s_addr(s_addr),
    .s_dtw(s_dtw), .s_ack(s_ack), .s_dtr(s_dtr), .m_stb(m_stb), .m_rw(m_rw),
    .m_addr(m_addr), .m_dtw(m_dtw), .m_ack(m_ack), .m_dtr(m_dtr),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct { logic rw; logic [31:0] addr; logic [31:0] dtw; } mreq_t;
  typedef struct { logic [NPORTS-1:0] ack; logic [31:0] dtr; } sresp_t;

  mreq_t  exp_m[$];
  sresp_t exp_s[$];

  int n_cmp = 0;
  int n_bad = 0;

  // requester-side stimulus values
  logic        tb_rw   [NPORTS];
  logic [31:0] tb_addr [NPORTS];
  logic [31:0] tb_dtw  [NPORTS];

  // SRAM controller model controls
  bit          ctrl_busy = 1'b0;
  int          ctrl_cnt  = 0;
  int          fix_lat   = -1;
  bit          fix_dtr_en = 1'b0;
  logic [31:0] fix_dtr   = 32'h0;
  bit          stray_en  = 1'b0;
  bit          force_ack = 1'b0;

  // reference model state
  bit [NPORTS-1:0] mdl_pend = '0;
  logic            mdl_rw   [NPORTS];
  logic [31:0]     mdl_addr [NPORTS];
  logic [31:0]     mdl_dtw  [NPORTS];
  bit              mdl_wait = 1'b0;
  int              mdl_grant = 0;
  int              mdl_last  = NPORTS - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // arbitration rule: first pending port after the last grant (RR) or lowest index
  function automatic int choose(input bit [NPORTS-1:0] p, input int last);
    for (int k = 1; k <= NPORTS; k++) begin
      int c;
      c = RR ? (last + k) % NPORTS : k - 1;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  // behavioural model, evaluated on the same sampled inputs as the DUT
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mdl_pend  = '0;
        mdl_wait  = 1'b0;
        mdl_grant = 0;
        mdl_last  = NPORTS - 1;
      end else begin
        bit [NPORTS-1:0] old;
        old = mdl_pend;
        if (mdl_wait) begin
          if (m_ack) begin
            sresp_t r;
            r.ack = '0;
            r.ack[mdl_grant] = 1'b1;
            r.dtr = m_dtr;
            exp_s.push_back(r);
            mdl_pend[mdl_grant] = 1'b0;
            mdl_wait = 1'b0;
          end
        end else if (old != '0) begin
          int p;
          mreq_t q;
          p = choose(old, mdl_last);
          q.rw = mdl_rw[p]; q.addr = mdl_addr[p]; q.dtw = mdl_dtw[p];
          exp_m.push_back(q);
          mdl_grant = p;
          mdl_last  = p;
          mdl_wait  = 1'b1;
        end
        for (int i = 0; i < NPORTS; i++) begin
          if (s_stb[i] && !old[i]) begin
            mdl_pend[i] = 1'b1;
            mdl_rw[i]   = s_rw[i];
            mdl_addr[i] = s_addr[32*i +: 32];
            mdl_dtw[i]  = s_dtw[32*i +: 32];
          end
        end
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a strobe or an ack
  initial begin
    logic prev_stb;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (m_stb === 1'b1 || exp_m.size() != 0) begin
        if (exp_m.size() == 0) begin
          chk("m_stb_spurious", {63'd0, m_stb}, 64'd0);
        end else begin
          mreq_t e;
          e = exp_m.pop_front();
          chk("m_stb", {63'd0, m_stb}, 64'd1);
          chk("m_rw", {63'd0, m_rw}, {63'd0, e.rw});
          chk("m_addr", {32'd0, m_addr}, {32'd0, e.addr});
          chk("m_dtw", {32'd0, m_dtw}, {32'd0, e.dtw});
        end
        if (m_stb === 1'b1) chk("m_stb_held", {63'd0, prev_stb}, 64'd0);
      end
      if (s_ack !== '0 || exp_s.size() != 0) begin
        if (exp_s.size() == 0) begin
          chk("s_ack_spurious", {{(64-NPORTS){1'b0}}, s_ack}, 64'd0);
        end else begin
          sresp_t r;
          r = exp_s.pop_front();
          chk("s_ack", {{(64-NPORTS){1'b0}}, s_ack}, {{(64-NPORTS){1'b0}}, r.ack});
          chk("s_dtr", {32'd0, s_dtr}, {32'd0, r.dtr});
        end
      end
      chk("busy", {63'd0, busy}, {63'd0, mdl_wait});
      chk("grant", {{(64-PW){1'b0}}, grant}, 64'(mdl_grant));
      prev_stb = m_stb;
    end
  end

  // one clock: controller model reacts, then new requester inputs are applied
  task automatic step(input logic rst, input logic [NPORTS-1:0] stb);
    @(posedge clk);
    #1;
    m_ack = 1'b0;
    m_dtr = $urandom();
    if (reset) begin
      ctrl_busy = 1'b0;
    end else if (ctrl_busy) begin
      if (ctrl_cnt == 0) begin
        m_ack = 1'b1;
        if (fix_dtr_en) m_dtr = fix_dtr;
        ctrl_busy = 1'b0;
      end else begin
        ctrl_cnt--;
      end
    end else if (m_stb) begin
      ctrl_busy = 1'b1;
      ctrl_cnt  = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 4));
    end else if (force_ack || (stray_en && $urandom_range(0, 19) == 0)) begin
      m_ack = 1'b1;
    end
    reset = rst;
    s_stb = stb;
    for (int i = 0; i < NPORTS; i++) begin
      s_rw[i]            = tb_rw[i];
      s_addr[32*i +: 32] = tb_addr[i];
      s_dtw[32*i +: 32]  = tb_dtw[i];
    end
  endtask

  initial begin
    logic [31:0] seen [2];
    int nseen;
    bit drained;
    reset = 1'b1; s_stb = '0; s_rw = '0; s_addr = '0; s_dtw = '0;
    m_ack = 1'b0; m_dtr = 32'h0;
    for (int i = 0; i < NPORTS; i++) begin
      tb_rw[i] = 1'b0; tb_addr[i] = 32'h0; tb_dtw[i] = 32'h0;
    end
    step(1'b1, '0);
    step(1'b1, '0);
    step(1'b0, '0);
    // reset state
    chk("rst_m_stb", {63'd0, m_stb}, 64'd0);
    chk("rst_m_addr", {32'd0, m_addr}, 64'd0);
    chk("rst_m_dtw", {32'd0, m_dtw}, 64'd0);
    chk("rst_s_ack", {{(64-NPORTS){1'b0}}, s_ack}, 64'd0);
    chk("rst_s_dtr", {32'd0, s_dtr}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);

    // single read on port 1, ack data DEADBEEF four cycles after the strobe
    fix_lat = 3; fix_dtr_en = 1'b1; fix_dtr = 32'hDEADBEEF;
    tb_addr[1] = 32'h0000_1002; tb_rw[1] = 1'b0;
    step(1'b0, 3'b010);                       // cycle 0
    step(1'b0, '0);                           // cycle 1
    chk("t1_c1_m_stb", {63'd0, m_stb}, 64'd0);
    step(1'b0, '0);                           // cycle 2
    chk("t1_c2_m_stb", {63'd0, m_stb}, 64'd1);
    chk("t1_c2_m_addr", {32'd0, m_addr}, 64'h1002);
    chk("t1_c2_m_rw", {63'd0, m_rw}, 64'd0);
    chk("t1_c2_busy", {63'd0, busy}, 64'd1);
    for (int c = 3; c <= 7; c++) step(1'b0, '0);
    chk("t1_c7_s_ack", {{(64-NPORTS){1'b0}}, s_ack}, 64'b010);
    chk("t1_c7_s_dtr", {32'd0, s_dtr}, 64'hDEADBEEF);
    fix_dtr_en = 1'b0;

    // ports 0 and 1 write in the same cycle: port 0 first in both modes
    fix_lat = 1;
    tb_rw[0] = 1'b1; tb_dtw[0] = 32'h11; tb_rw[1] = 1'b1; tb_dtw[1] = 32'h22;
    step(1'b0, 3'b011);
    nseen = 0;
    for (int c = 0; c < 40 && nseen < 2; c++) begin
      step(1'b0, '0);
      if (m_stb) begin
        seen[nseen] = m_dtw;
        nseen++;
      end
    end
    chk("t2_count", 64'(nseen), 64'd2);
    chk("t2_first", {32'd0, seen[0]}, 64'h11);
    chk("t2_second", {32'd0, seen[1]}, 64'h22);
    for (int c = 0; c < 6; c++) step(1'b0, '0);

    // re-strobe on a pending port is dropped
    tb_addr[1] = 32'h0000_00A0; tb_rw[1] = 1'b0;
    step(1'b0, 3'b010);
    tb_addr[1] = 32'h0000_00B0;
    step(1'b0, 3'b010);
    for (int c = 0; c < 10; c++) step(1'b0, '0);

    // reset while in WAIT, then a stray ack while idle
    fix_lat = 3;
    step(1'b0, 3'b001);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t5_busy_before", {63'd0, busy}, 64'd1);
    step(1'b1, '0);
    step(1'b0, '0);
    chk("t5_busy_after", {63'd0, busy}, 64'd0);
    chk("t5_s_ack_after", {{(64-NPORTS){1'b0}}, s_ack}, 64'd0);
    force_ack = 1'b1;
    step(1'b0, '0);
    force_ack = 1'b0;
    step(1'b0, '0);
    chk("t5_stray_s_ack", {{(64-NPORTS){1'b0}}, s_ack}, 64'd0);
    chk("t5_stray_busy", {63'd0, busy}, 64'd0);

    // randomized traffic with protocol violations, stray acks and resets
    fix_lat = -1; stray_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      logic [NPORTS-1:0] stb;
      for (int i = 0; i < NPORTS; i++) begin
        stb[i]     = ($urandom_range(0, 2) == 0);
        tb_rw[i]   = 1'($urandom_range(0, 1));
        tb_addr[i] = $urandom();
        tb_dtw[i]  = $urandom();
      end
      step(($urandom_range(0, 399) == 0), stb);
    end

    // drain with a bounded budget
    stray_en = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      step(1'b0, '0);
      drained = !mdl_wait && (mdl_pend == '0) && (exp_m.size() == 0) && (exp_s.size() == 0);
    end
    step(1'b0, '0);
    step(1'b0, '0);
    chk("drain_done", {63'd0, drained}, 64'd1);
    chk("drain_exp_m", 64'(exp_m.size()), 64'd0);
    chk("drain_exp_s", 64'(exp_s.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
